// File: rtl/uart_tx_decoder.sv
// Serial receiver for the SoC UART transmit pin: decodes 8N1 frames into a FWFT byte FIFO.
// Define UART_TX_DECODER_PARITY_EN to decode 8E1 frames and flag even-parity mismatches.
module uart_tx_decoder #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  output logic [7:0]                    byte_o,
  output logic                          byte_valid_o,
  input  logic                          byte_ready_i,
  output logic                          eol_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W        = $clog2(FIFO_DEPTH);
  localparam int PTR_W        = IDX_W + 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W-1:0] LVL_FULL = PTR_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_TX_DECODER_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  // Line synchroniser; flops reset to the idle (high) level so reset release
  // with the line low is seen as a falling edge.
  logic rx_meta, rx_s, rx_s_d;
  logic rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so each flop takes the pre-edge value of its source.
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign rx_fall = rx_s_d & ~rx_s;

  // Frame FSM
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             cnt_hit;
  logic             push_req;
  logic             ferr;
  logic             byte_ok;
`ifdef UART_TX_DECODER_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             perr;
  assign byte_ok = ~par_bad_q;
`else
  assign byte_ok = 1'b1;
`endif

  assign cnt_hit = (cnt_q == CNT_FULL);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr     = 1'b0;
`ifdef UART_TX_DECODER_PARITY_EN
    par_bad_d = par_bad_q;
    perr      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_fall) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          bit_d = 3'd0;
`ifdef UART_TX_DECODER_PARITY_EN
          par_bad_d = 1'b0;
`endif
          // A start bit that is high again by mid-bit was a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_hit) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_DECODER_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_DECODER_PARITY_EN
      S_PARITY: begin
        if (cnt_hit) begin
          cnt_d   = '0;
          state_d = S_STOP;
          // Even parity: data ones plus the parity bit must be even.
          if (rx_s != ^shift_q) begin
            perr      = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (cnt_hit) begin
          cnt_d = '0;
          if (rx_s) begin
            push_req = byte_ok;
            state_d  = S_IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
`ifdef UART_TX_DECODER_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_TX_DECODER_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  // Byte FIFO: pointers carry one wrap bit so full and empty are distinguishable.
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] level;
  logic [PTR_W-1:0] remain;
  logic [IDX_W-1:0] rd_next_idx;
  logic             full;
  logic             pop;
  logic             push;

  assign level       = wr_ptr - rd_ptr;
  assign full        = (level == LVL_FULL);
  assign pop         = byte_valid_o & byte_ready_i;
  assign push        = push_req & (~full | pop);
  assign remain      = level - PTR_W'(pop);
  assign rd_next_idx = rd_ptr[IDX_W-1:0] + IDX_W'(pop);

  // NOTE: the storage array is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= shift_q;
  end

  // byte_o tracks the head after this edge's push/pop; when the FIFO will hold
  // only the incoming byte, that byte bypasses the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
      byte_o     <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push) overflow_o <= 1'b1;
      byte_o <= (remain == '0) ? shift_q : mem[rd_next_idx];
    end
  end

  assign byte_valid_o = (level != '0);
  assign fifo_level_o = level;
  assign eol_o        = push & (shift_q == 8'h0A);
  assign frame_err_o  = ferr;
`ifdef UART_TX_DECODER_PARITY_EN
  assign parity_err_o = perr;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
